if_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC register and the IF/ID pipeline register.
//  - Current PC drives instruction memory and the PC/offset adder's 11-bit old_pc input.
//  - Takes the adder's new_pc result back as branch_target when a branch resolves taken.
//  - Handles hazard-unit stalls, branch flushes and a HALT instruction.

---
 rtl/if_stage.sv | 107 ++++++++++
 tb/tb_if_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, HALT handling.
// Optional fetch counter port enabled by defining IF_FETCH_CNT_EN.
module if_stage #(
    parameter int                  PC_W       = 11,
    parameter int                  INSTR_W    = 32,
    parameter logic [PC_W-1:0]     RESET_PC   = '0,
    parameter logic [INSTR_W-1:0]  HALT_INSTR = '1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc_plus1,
    output logic               if_id_valid,
    output logic               halted
`ifdef IF_FETCH_CNT_EN
    ,
    output logic [15:0]        fetch_count
`endif
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e             state;
    state_e             state_nxt;
    logic [PC_W-1:0]    pc_nxt;
    logic [PC_W-1:0]    pc_inc;
    logic [INSTR_W-1:0] instr_nxt;
    logic [PC_W-1:0]    pp1_nxt;
    logic               valid_nxt;

    // pc+1 wraps naturally within PC_W bits
    assign pc_inc = pc + PC_W'(1);
    assign halted = (state == HALT);

    // Register update: reset restores everything, else take next values
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            pc             <= RESET_PC;
            if_id_instr    <= '0;
            if_id_pc_plus1 <= '0;
            if_id_valid    <= 1'b0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            if_id_instr    <= instr_nxt;
            if_id_pc_plus1 <= pp1_nxt;
            if_id_valid    <= valid_nxt;
        end
    end

    // Next state: branch redirect beats stall, stall beats normal fetch
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = if_id_instr;
        pp1_nxt   = if_id_pc_plus1;
        valid_nxt = if_id_valid;
        if (branch_taken) begin
            state_nxt = RUN;
            pc_nxt    = branch_target;
            instr_nxt = '0;
            pp1_nxt   = '0;
            valid_nxt = 1'b0;
        end else if (!stall) begin
            unique case (state)
                RUN: begin
                    instr_nxt = imem_data;
                    pp1_nxt   = pc_inc;
                    valid_nxt = 1'b1;
                    if (imem_data == HALT_INSTR) begin
                        state_nxt = HALT;
                    end else begin
                        pc_nxt = pc_inc;
                    end
                end
                HALT: begin
                    instr_nxt = '0;
                    valid_nxt = 1'b0;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

`ifdef IF_FETCH_CNT_EN
    // Count edges that load a real instruction into IF/ID
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (!branch_taken && !stall && state == RUN) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table fed through a scoreboard
// queue, plus a hand-written reset-during-HALT sequence.
module tb_if_stage;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
    localparam logic [10:0] HALT_PC = 11'd20;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [10:0] branch_target;
    logic [31:0] imem_data;
    logic [10:0] pc;
    logic [31:0] if_id_instr;
    logic [10:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic        halted;
`ifdef IF_FETCH_CNT_EN
    logic [15:0] fetch_count;
`endif

    int checks = 0;
    int failures = 0;
    int cnt_exp = 0;

    typedef struct {
        logic        rst;
        logic        st;
        logic        br;
        logic [10:0] tgt;
        logic [10:0] pc;
        logic [31:0] instr;
        logic [10:0] pp1;
        logic        v;
        logic        h;
    } vec_t;

    typedef struct {
        logic [10:0] pc;
        logic [31:0] instr;
        logic [10:0] pp1;
        logic        v;
        logic        h;
        int          cnt;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_data      (imem_data),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid),
        .halted         (halted)
`ifdef IF_FETCH_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory model: pc+100, with a HALT word planted at HALT_PC
    always_comb begin
        imem_data = 32'(pc) + 32'd100;
        if (pc == HALT_PC) imem_data = HALT_W;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, req, $time);
        end
    endtask

    task automatic add(input logic rst, input logic st, input logic br,
                       input logic [10:0] tgt, input logic [10:0] epc,
                       input logic [31:0] ei, input logic [10:0] ep,
                       input logic ev, input logic eh);
        vec_t r;
        r.rst = rst; r.st = st; r.br = br; r.tgt = tgt;
        r.pc = epc; r.instr = ei; r.pp1 = ep; r.v = ev; r.h = eh;
        vt.push_back(r);
    endtask

    task automatic step(input vec_t r, input int idx);
        exp_t e;
        @(negedge clk);
        reset         = r.rst;
        stall         = r.st;
        branch_taken  = r.br;
        branch_target = r.tgt;
        if (r.rst) cnt_exp = 0;
        else if (!r.st && !r.br && r.v) cnt_exp = (cnt_exp + 1) % 65536;
        e.pc = r.pc; e.instr = r.instr; e.pp1 = r.pp1;
        e.v = r.v; e.h = r.h; e.cnt = cnt_exp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("sb_empty[%0d]", idx), 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("pc[%0d]", idx), 32'(pc), 32'(e.pc));
            chk($sformatf("instr[%0d]", idx), if_id_instr, e.instr);
            chk($sformatf("pp1[%0d]", idx), 32'(if_id_pc_plus1), 32'(e.pp1));
            chk($sformatf("valid[%0d]", idx), 32'(if_id_valid), 32'(e.v));
            chk($sformatf("halted[%0d]", idx), 32'(halted), 32'(e.h));
`ifdef IF_FETCH_CNT_EN
            chk($sformatf("fcnt[%0d]", idx), 32'(fetch_count), 32'(e.cnt));
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

        // rst st br tgt    pc      instr         pp1    v  h
        add(1, 0, 0, 0,     0,      0,            0,     0, 0);
        add(1, 0, 0, 0,     0,      0,            0,     0, 0);
        add(0, 0, 0, 0,     1,      100,          1,     1, 0);
        add(0, 0, 0, 0,     2,      101,          2,     1, 0);
        add(0, 0, 0, 0,     3,      102,          3,     1, 0);
        add(0, 0, 0, 0,     4,      103,          4,     1, 0);
        add(0, 0, 0, 0,     5,      104,          5,     1, 0);
        add(0, 1, 0, 0,     5,      104,          5,     1, 0);
        add(0, 1, 0, 0,     5,      104,          5,     1, 0);
        add(0, 1, 0, 0,     5,      104,          5,     1, 0);
        add(0, 0, 0, 0,     6,      105,          6,     1, 0);
        add(0, 0, 0, 0,     7,      106,          7,     1, 0);
        add(0, 0, 0, 0,     8,      107,          8,     1, 0);
        add(0, 0, 0, 0,     9,      108,          9,     1, 0);
        add(0, 1, 1, 11'h040, 11'h040, 0,         0,     0, 0);
        add(0, 0, 0, 0,     11'h041, 164,         11'h041, 1, 0);
        add(0, 0, 1, 11'h7FF, 11'h7FF, 0,         0,     0, 0);
        add(0, 0, 0, 0,     0,      2147,         0,     1, 0);
        add(0, 0, 0, 0,     1,      100,          1,     1, 0);
        add(0, 0, 1, 20,    20,     0,            0,     0, 0);
        add(0, 0, 0, 0,     20,     HALT_W,       21,    1, 1);
        add(0, 0, 0, 0,     20,     0,            21,    0, 1);
        add(0, 1, 0, 0,     20,     0,            21,    0, 1);
        add(0, 0, 1, 30,    30,     0,            0,     0, 0);
        add(0, 0, 0, 0,     31,     130,          31,    1, 0);
        add(1, 0, 1, 11'h055, 0,    0,            0,     0, 0);
        add(0, 0, 0, 0,     1,      100,          1,     1, 0);
        add(0, 1, 0, 0,     1,      100,          1,     1, 0);
        add(1, 1, 0, 0,     0,      0,            0,     0, 0);
        add(0, 0, 0, 0,     1,      100,          1,     1, 0);

        foreach (vt[i]) step(vt[i], i);

        // Reset while halted: redirect to the HALT word, wait for halt
        @(negedge clk);
        branch_taken = 1'b1; branch_target = HALT_PC; stall = 1'b0;
        @(negedge clk);
        branch_taken = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (halted) seen = 1'b1;
        end
        chk("halt_reached", 32'(seen), 32'd1);
        chk("halt_pc", 32'(pc), 32'(HALT_PC));
        chk("halt_instr", if_id_instr, HALT_W);
        @(negedge clk);
        reset = 1'b1; stall = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_halt_pc", 32'(pc), 32'd0);
        chk("rst_halt_h", 32'(halted), 32'd0);
        chk("rst_halt_v", 32'(if_id_valid), 32'd0);
        chk("rst_halt_i", if_id_instr, 32'd0);
`ifdef IF_FETCH_CNT_EN
        chk("rst_halt_cnt", 32'(fetch_count), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0; stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
